ctrl_pipe_unit: RTL and testbench
=================================

# ctrl_pipe_unit

Pipelined control unit for the RV-subset core. Decodes the instruction in ID into a parametrised control bundle and carries that bundle through registered EX, MEM and WB stage slots. Detects load-use hazards, inserts bubbles, and squashes the ID instruction on a taken branch. Extends single-cycle decode with more ALU operations, BNE support, and hazard and flush sequencing.

## Interface
Parameters:
- ALU_CTRL_W, default 4: width of the ALU control code. Must be ≥ 3.
- REG_ADDR_W, default 5: register index width.

Ports:
- clk  in  1  core clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- opcode  in  7, funct3  in  3, funct7  in  7  ID instruction fields.
- rs1, rs2, rd  in  REG_ADDR_W  ID register indices.
- branch_taken  in  1  EX-stage branch resolved taken. Flush request.
- stall  out  1  hold PC and IF/ID (combinational).
- ex_alu_control  out  ALU_CTRL_W; ex_alu_src, ex_branch, ex_branch_ne, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  out  1; ex_rd  out  REG_ADDR_W.
- mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write  out  1; mem_rd  out  REG_ADDR_W.
- wb_reg_write, wb_mem_to_reg  out  1; wb_rd  out  REG_ADDR_W.
- illegal  out  1  sticky illegal-opcode flag. Present only with the macro defined (see Configuration).

## Operation
Decode (combinational, ID). Only the control fields that differ from the bubble (all zero, alu ADD) are listed:
- Load 0000011: ADD, alu_src, mem_read, mem_to_reg, reg_write.
- I-ALU 0010011: ADD, alu_src, reg_write.
- Store 0100011: ADD, alu_src, mem_write.
- R 0110011: reg_write. ALU code from funct3/funct7:
  - 000 with funct7 0100000 → SUB; 000 otherwise → ADD.
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL.
  - Any other funct3 → ADD.
- Branch 1100011: SUB, branch. funct3 001 also sets branch_ne. Any other funct3 is treated as BEQ.
- ALU codes, zero-extended to ALU_CTRL_W: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLL 6, SRL 7.
- Unknown opcode, or id_valid=0: decodes to a bubble.
- rs2 is "used" only for R, store and branch.

Hazard and stall:
- stall = ex_mem_read & (ex_rd≠0) & id_valid & ((ex_rd==rs1) | (rs2 used & ex_rd==rs2)) & ~branch_taken.

Stage advance, every cycle:
- WB ← MEM, MEM ← EX, unconditionally.
- EX ← bubble if branch_taken or stall; otherwise EX ← decoded ID bundle.
- branch_taken has priority over stall: a squashed instruction never stalls.
- The branch itself, already in EX, advances into MEM normally. It has no write side effects.

Reset:
- Asynchronous. Every stage slot is cleared to a bubble: all outputs 0, alu code ADD, rd 0.
- Reset asserted mid-stall or mid-flush discards all in-flight control with no residue.
- stall is 0 out of reset because EX is empty.

## Timing
- ID decode to ex_* outputs: 1 cycle. To mem_*: 2 cycles. To wb_*: 3 cycles.
- stall is combinational from current ID fields and EX state, same cycle.
- A load-use stall lasts exactly 1 cycle. Next cycle EX holds the bubble, so ex_mem_read=0 and stall drops.
- Back-to-back loads with a dependency stall once per dependent pair.
- A flush inserts exactly one bubble into EX.
- Writes to rd=0 still propagate reg_write. Suppressing them is the register file's job.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - An unknown opcode with id_valid=1 and no flush sets illegal on the next edge.
  - The instruction still enters EX as a bubble.
  - illegal stays 1 until rst.
- CTRL_ILLEGAL_TRAP_EN undefined:
  - The illegal port does not exist.
  - Unknown opcodes silently become bubbles.
  - No simulation messages are emitted.

## Test plan
- R sweep: opcode 0110011 with funct3 000/funct7 0100000, then 111, 100, 010. Next cycle ex_alu_control = 1, 2, 4, 5 and ex_reg_write=1. Three cycles after issue, wb_reg_write=1.
- Load-use: load rd=5, then ADD rs1=5. stall=1 for one cycle. EX gets a bubble (ex_reg_write=0). The ADD appears in EX one cycle later.
- False hazard: load rd=0 followed by a use of x0, and I-ALU rs2 field=5 after load rd=5. stall stays 0 in both cases.
- Flush priority: branch_taken=1 while ID holds a dependent load-use consumer. stall=0. Next cycle EX is a bubble. The branch appears in MEM with all write enables 0.
- BNE: opcode 1100011, funct3 001 → ex_branch=1, ex_branch_ne=1, ex_alu_control=1.
- Reset mid-flight: load a three-instruction sequence, assert rst asynchronously between edges. All outputs 0 immediately, and illegal clears. With CTRL_ILLEGAL_TRAP_EN, opcode 1111111 afterwards sets illegal=1 on the next edge, and it holds.

Source files
------------

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decodes ID into a control bundle, carries it through EX/MEM/WB,
// and handles load-use stalls and branch flushes. Optional sticky illegal flag: CTRL_ILLEGAL_TRAP_EN.
module ctrl_pipe_unit #(
    parameter int ALU_CTRL_W = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic [ALU_CTRL_W-1:0] ex_alu_control,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_branch_ne,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_reg_write,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_to_reg,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_rd
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                  illegal
`endif
);

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'd0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'd1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'd2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'd3);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = ALU_CTRL_W'(3'd4);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'd5);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(3'd6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = ALU_CTRL_W'(3'd7);

    logic [ALU_CTRL_W-1:0] w_alu;
    logic                  w_alu_src, w_branch, w_branch_ne, w_mem_read, w_mem_write;
    logic                  w_mem_to_reg, w_reg_write, w_rs2_used, w_known;
    logic [REG_ADDR_W-1:0] w_rd;
    logic                  w_squash;

    logic [ALU_CTRL_W-1:0] r_ex_alu;
    logic                  r_ex_alu_src, r_ex_branch, r_ex_branch_ne, r_ex_mem_read;
    logic                  r_ex_mem_write, r_ex_mem_to_reg, r_ex_reg_write;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_mem_mem_read, r_mem_mem_write, r_mem_mem_to_reg, r_mem_reg_write;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_wb_reg_write, r_wb_mem_to_reg;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    // Only instructions that write a register carry rd forward; others leave it 0.
    always_comb begin
        w_alu        = ALU_ADD;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        w_branch_ne  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_rs2_used   = 1'b0;
        w_known      = 1'b0;
        w_rd         = '0;
        if (id_valid) begin
            case (opcode)
                OP_LOAD: begin
                    w_known      = 1'b1;
                    w_alu_src    = 1'b1;
                    w_mem_read   = 1'b1;
                    w_mem_to_reg = 1'b1;
                    w_reg_write  = 1'b1;
                    w_rd         = rd;
                end
                OP_IALU: begin
                    w_known     = 1'b1;
                    w_alu_src   = 1'b1;
                    w_reg_write = 1'b1;
                    w_rd        = rd;
                end
                OP_STORE: begin
                    w_known     = 1'b1;
                    w_alu_src   = 1'b1;
                    w_mem_write = 1'b1;
                    w_rs2_used  = 1'b1;
                end
                OP_R: begin
                    w_known     = 1'b1;
                    w_reg_write = 1'b1;
                    w_rs2_used  = 1'b1;
                    w_rd        = rd;
                    case (funct3)
                        3'b000:  w_alu = (funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
                        3'b111:  w_alu = ALU_AND;
                        3'b110:  w_alu = ALU_OR;
                        3'b100:  w_alu = ALU_XOR;
                        3'b010:  w_alu = ALU_SLT;
                        3'b001:  w_alu = ALU_SLL;
                        3'b101:  w_alu = ALU_SRL;
                        default: w_alu = ALU_ADD;
                    endcase
                end
                OP_BRANCH: begin
                    w_known     = 1'b1;
                    w_alu       = ALU_SUB;
                    w_branch    = 1'b1;
                    w_branch_ne = (funct3 == 3'b001);
                    w_rs2_used  = 1'b1;
                end
                default: w_known = 1'b0;
            endcase
        end
    end

    // A flushed instruction never stalls, hence the ~branch_taken term.
    assign stall = r_ex_mem_read & (r_ex_rd != '0) & id_valid &
                   ((r_ex_rd == rs1) | (w_rs2_used & (r_ex_rd == rs2))) & ~branch_taken;
    assign w_squash = branch_taken | stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_alu         <= ALU_ADD;
            r_ex_alu_src     <= 1'b0;
            r_ex_branch      <= 1'b0;
            r_ex_branch_ne   <= 1'b0;
            r_ex_mem_read    <= 1'b0;
            r_ex_mem_write   <= 1'b0;
            r_ex_mem_to_reg  <= 1'b0;
            r_ex_reg_write   <= 1'b0;
            r_ex_rd          <= '0;
            r_mem_mem_read   <= 1'b0;
            r_mem_mem_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_rd         <= '0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_wb_rd          <= '0;
        end else begin
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_rd          <= r_mem_rd;
            r_mem_mem_read   <= r_ex_mem_read;
            r_mem_mem_write  <= r_ex_mem_write;
            r_mem_mem_to_reg <= r_ex_mem_to_reg;
            r_mem_reg_write  <= r_ex_reg_write;
            r_mem_rd         <= r_ex_rd;
            if (w_squash) begin
                r_ex_alu        <= ALU_ADD;
                r_ex_alu_src    <= 1'b0;
                r_ex_branch     <= 1'b0;
                r_ex_branch_ne  <= 1'b0;
                r_ex_mem_read   <= 1'b0;
                r_ex_mem_write  <= 1'b0;
                r_ex_mem_to_reg <= 1'b0;
                r_ex_reg_write  <= 1'b0;
                r_ex_rd         <= '0;
            end else begin
                r_ex_alu        <= w_alu;
                r_ex_alu_src    <= w_alu_src;
                r_ex_branch     <= w_branch;
                r_ex_branch_ne  <= w_branch_ne;
                r_ex_mem_read   <= w_mem_read;
                r_ex_mem_write  <= w_mem_write;
                r_ex_mem_to_reg <= w_mem_to_reg;
                r_ex_reg_write  <= w_reg_write;
                r_ex_rd         <= w_rd;
            end
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (id_valid & ~w_known & ~branch_taken) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`endif

    assign ex_alu_control = r_ex_alu;
    assign ex_alu_src     = r_ex_alu_src;
    assign ex_branch      = r_ex_branch;
    assign ex_branch_ne   = r_ex_branch_ne;
    assign ex_mem_read    = r_ex_mem_read;
    assign ex_mem_write   = r_ex_mem_write;
    assign ex_mem_to_reg  = r_ex_mem_to_reg;
    assign ex_reg_write   = r_ex_reg_write;
    assign ex_rd          = r_ex_rd;
    assign mem_mem_read   = r_mem_mem_read;
    assign mem_mem_write  = r_mem_mem_write;
    assign mem_mem_to_reg = r_mem_mem_to_reg;
    assign mem_reg_write  = r_mem_reg_write;
    assign mem_rd         = r_mem_rd;
    assign wb_reg_write   = r_wb_reg_write;
    assign wb_mem_to_reg  = r_wb_mem_to_reg;
    assign wb_rd          = r_wb_rd;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed vector bench for ctrl_pipe_unit: table of ID inputs with expected stall/EX bundle,
// a small MEM/WB shift model, and hand sequences for async reset and the illegal flag.
module tb_ctrl_pipe_unit;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] IA = 7'b0010011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] RR = 7'b0110011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;
    // flag order: {alu_src, branch, branch_ne, mem_read, mem_write, mem_to_reg, reg_write}
    localparam logic [6:0] F_LD = 7'b1001011;
    localparam logic [6:0] F_IA = 7'b1000001;
    localparam logic [6:0] F_ST = 7'b1000100;
    localparam logic [6:0] F_R  = 7'b0000001;
    localparam logic [6:0] F_BQ = 7'b0100000;
    localparam logic [6:0] F_BN = 7'b0110000;
    localparam logic [6:0] F_0  = 7'b0000000;

    typedef struct {
        logic       v;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rs1, rs2, rd;
        logic       bt;
        logic       e_stall;
        logic [3:0] e_alu;
        logic [6:0] e_fl;
        logic [4:0] e_rd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    logic       branch_taken;
    logic       stall;
    logic [3:0] ex_alu_control;
    logic       ex_alu_src, ex_branch, ex_branch_ne, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
    logic       wb_reg_write, wb_mem_to_reg;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ctrl_pipe_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .branch_taken(branch_taken), .stall(stall),
        .ex_alu_control(ex_alu_control), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_branch_ne(ex_branch_ne), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic v, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                int a, int b, int d, logic bt, logic st, int alu,
                                logic [6:0] fl, int erd);
        vec_t t;
        t.v = v; t.op = op; t.f3 = f3; t.f7 = f7;
        t.rs1 = 5'(a); t.rs2 = 5'(b); t.rd = 5'(d); t.bt = bt;
        t.e_stall = st; t.e_alu = 4'(alu); t.e_fl = fl; t.e_rd = 5'(erd);
        return t;
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] d, input logic bt);
        id_valid = v; opcode = op; funct3 = f3; funct7 = f7;
        rs1 = a; rs2 = b; rd = d; branch_taken = bt;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"}, 32'(stall), 0);
        chk({tag, " ex"}, {ex_alu_control, ex_alu_src, ex_branch, ex_branch_ne, ex_mem_read,
                           ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_rd}, 0);
        chk({tag, " mem"}, {mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_rd}, 0);
        chk({tag, " wb"}, {wb_reg_write, wb_mem_to_reg, wb_rd}, 0);
    endtask

    localparam int NV = 29;
    vec_t vt[NV];

    // MEM/WB expectation model: {mr, mw, m2r, rw, rd, rd_checked}
    logic [9:0] m1, m2, cur;

    initial begin
        vt[0]  = mk(1, RR, 3'd0, 7'h20, 1, 2, 3, 0, 0, 1, F_R, 3);
        vt[1]  = mk(1, RR, 3'd7, 7'h00, 1, 2, 4, 0, 0, 2, F_R, 4);
        vt[2]  = mk(1, RR, 3'd4, 7'h00, 1, 2, 10, 0, 0, 4, F_R, 10);
        vt[3]  = mk(1, RR, 3'd2, 7'h00, 1, 2, 11, 0, 0, 5, F_R, 11);
        vt[4]  = mk(1, LD, 3'd2, 7'h00, 1, 0, 5, 0, 0, 0, F_LD, 5);
        vt[5]  = mk(1, RR, 3'd0, 7'h00, 5, 2, 6, 0, 1, 0, F_0, 0);
        vt[6]  = mk(1, RR, 3'd0, 7'h00, 5, 2, 6, 0, 0, 0, F_R, 6);
        vt[7]  = mk(1, LD, 3'd2, 7'h00, 2, 0, 0, 0, 0, 0, F_LD, 0);
        vt[8]  = mk(1, RR, 3'd0, 7'h00, 0, 0, 7, 0, 0, 0, F_R, 7);
        vt[9]  = mk(1, LD, 3'd2, 7'h00, 1, 0, 5, 0, 0, 0, F_LD, 5);
        vt[10] = mk(1, IA, 3'd0, 7'h00, 1, 5, 8, 0, 0, 0, F_IA, 8);
        vt[11] = mk(1, BR, 3'd1, 7'h00, 5, 1, 0, 0, 0, 1, F_BN, 0);
        vt[12] = mk(1, LD, 3'd2, 7'h00, 1, 0, 5, 1, 0, 0, F_0, 0);
        vt[13] = mk(1, LD, 3'd2, 7'h00, 1, 0, 5, 0, 0, 0, F_LD, 5);
        vt[14] = mk(1, RR, 3'd0, 7'h00, 5, 2, 9, 1, 0, 0, F_0, 0);
        vt[15] = mk(1, RR, 3'd0, 7'h00, 5, 5, 9, 0, 0, 0, F_R, 9);
        vt[16] = mk(1, ST, 3'd2, 7'h00, 1, 9, 3, 0, 0, 0, F_ST, 0);
        vt[17] = mk(1, LD, 3'd2, 7'h00, 1, 0, 12, 0, 0, 0, F_LD, 12);
        vt[18] = mk(1, LD, 3'd2, 7'h00, 12, 0, 13, 0, 1, 0, F_0, 0);
        vt[19] = mk(1, LD, 3'd2, 7'h00, 12, 0, 13, 0, 0, 0, F_LD, 13);
        vt[20] = mk(1, ST, 3'd2, 7'h00, 1, 13, 0, 0, 1, 0, F_0, 0);
        vt[21] = mk(1, ST, 3'd2, 7'h00, 1, 13, 0, 0, 0, 0, F_ST, 0);
        vt[22] = mk(1, BAD, 3'd0, 7'h00, 1, 2, 14, 0, 0, 0, F_0, 0);
        vt[23] = mk(0, RR, 3'd7, 7'h00, 1, 2, 15, 0, 0, 0, F_0, 0);
        vt[24] = mk(1, RR, 3'd1, 7'h00, 1, 2, 16, 0, 0, 6, F_R, 16);
        vt[25] = mk(1, RR, 3'd5, 7'h00, 1, 2, 17, 0, 0, 7, F_R, 17);
        vt[26] = mk(1, RR, 3'd3, 7'h20, 1, 2, 18, 0, 0, 0, F_R, 18);
        vt[27] = mk(1, BR, 3'd0, 7'h00, 1, 2, 0, 0, 0, 1, F_BQ, 0);
        vt[28] = mk(1, BR, 3'd5, 7'h00, 1, 2, 0, 0, 0, 1, F_BQ, 0);

        drive(0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
        rst = 1'b1;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m1 = 10'b1; m2 = 10'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i].v, vt[i].op, vt[i].f3, vt[i].f7, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].bt);
            #1;
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(vt[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex_alu", i), 32'(ex_alu_control), 32'(vt[i].e_alu));
            chk($sformatf("v%0d ex_flags", i),
                32'({ex_alu_src, ex_branch, ex_branch_ne, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write}),
                32'(vt[i].e_fl));
            cur = {vt[i].e_fl[3], vt[i].e_fl[2], vt[i].e_fl[1], vt[i].e_fl[0], vt[i].e_rd,
                   vt[i].e_fl[0] | ~(vt[i].e_fl[2] | vt[i].e_fl[5])};
            if (cur[0]) chk($sformatf("v%0d ex_rd", i), 32'(ex_rd), 32'(vt[i].e_rd));
            chk($sformatf("v%0d mem_ctl", i),
                32'({mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write}), 32'(m1[9:6]));
            if (m1[0]) chk($sformatf("v%0d mem_rd", i), 32'(mem_rd), 32'(m1[5:1]));
            chk($sformatf("v%0d wb_ctl", i), 32'({wb_reg_write, wb_mem_to_reg}), 32'({m2[6], m2[7]}));
            if (m2[0]) chk($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(m2[5:1]));
            m2 = m1;
            m1 = cur;
        end

`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("illegal sticky before reset", 32'(illegal), 1);
`endif
        // Reset mid-flight: I-ALU, R, load in the pipe, consumer stalling in ID.
        @(negedge clk); drive(1, IA, 3'd0, 7'd0, 5'd1, 5'd0, 5'd4, 0);
        @(negedge clk); drive(1, RR, 3'd0, 7'd0, 5'd1, 5'd2, 5'd6, 0);
        @(negedge clk); drive(1, LD, 3'd2, 7'd0, 5'd1, 5'd0, 5'd5, 0);
        @(negedge clk); drive(1, RR, 3'd0, 7'd0, 5'd5, 5'd2, 5'd7, 0);
        #1;
        chk("pre-reset stall", 32'(stall), 1);
        chk("pre-reset wb_reg_write", 32'(wb_reg_write), 1);
        chk("pre-reset mem_rd", 32'(mem_rd), 6);
        rst = 1'b1;
        #1;
        chk_all_zero("async reset");
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("illegal after reset", 32'(illegal), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        drive(1, BAD, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
        @(posedge clk);
        #1;
        chk("bad op ex bubble", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}), 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("illegal set", 32'(illegal), 1);
        @(negedge clk); drive(1, RR, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 0);
        @(negedge clk); drive(0, RR, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 0);
        @(negedge clk);
        chk("illegal holds", 32'(illegal), 1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
